// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters.
// One frame in flight at a time: launch, wait for tx_done (or time out), then hold off for a guard gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [32*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       uart_start,
  output logic [31:0]                uart_data,
  input  logic                       uart_tx_done
);
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               terr_q, terr_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [31:0]        data_q, data_d;
  logic [IDW-1:0]     gid_q, gid_d;

  logic [31:0]    word [NUM_REQ];
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_idx;
  logic           win_vld;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign word[g] = req_data[32*g +: 32];
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ack_d   = '0;
    done_d  = '0;
    terr_d  = 1'b0;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d        = S_WAIT;
          ptr_d          = win_idx;
          gid_d          = win_idx;
          data_d         = word[win_idx];
          cnt_d          = '0;
          start_d        = 1'b1;
          ack_d[win_idx] = 1'b1;
        end
      end
      S_WAIT: begin
        // A tx_done landing on the timeout edge counts as a normal finish.
        if (uart_tx_done || (cnt_q == TO_LAST)) begin
          done_d[gid_q] = 1'b1;
          terr_d        = !uart_tx_done;
          cnt_d         = '0;
          state_d       = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;
  assign uart_start  = start_q;
  assign uart_data   = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one instance with a 16-cycle gap, one with no gap.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TO  = 100;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [1:0]  gid;
    logic        terr;
    int          at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_data = '0;
  logic            txd = 1'b0;
  logic [N-1:0]    ack, done;
  logic            terr, busy, start;
  logic [1:0]      gid;
  logic [31:0]     udata;

  logic [N-1:0]    req_g = '0;
  logic [32*N-1:0] req_data_g = '0;
  logic            txd_g = 1'b0;
  logic [N-1:0]    ack_g, done_g;
  logic            terr_g, busy_g, start_g;
  logic [1:0]      gid_g;
  logic [31:0]     udata_g;

  ev_t sq[$], dq[$], sq_g[$], dq_g[$];

  logic [3:0]  mtab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] dtab [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h11111111};
  logic [1:0]  gtab [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  int          dl   [5] = '{5, 10, 3, 7, 2};

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .timeout_err(terr), .busy(busy), .grant_id(gid), .uart_start(start),
    .uart_data(udata), .uart_tx_done(txd)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_g (
    .clk(clk), .rst(rst), .req(req_g), .req_data(req_data_g), .ack(ack_g), .done(done_g),
    .timeout_err(terr_g), .busy(busy_g), .grant_id(gid_g), .uart_start(start_g),
    .uart_data(udata_g), .uart_tx_done(txd_g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h with nothing expected (cycle %0d)", nm, act, cyc);
  endtask

  function automatic ev_t mk(input logic [3:0] m, input logic [31:0] d, input logic [1:0] g,
                             input logic t, input int a);
    ev_t e;
    e.mask = m;
    e.data = d;
    e.gid  = g;
    e.terr = t;
    e.at   = a;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (start || ack != '0) begin
      if (sq.size() == 0) unexpected("start", 32'(ack));
      else begin
        e = sq.pop_front();
        chk("start_pulse", 32'(start), 32'd1);
        chk("start_ack", 32'(ack), 32'(e.mask));
        chk("start_data", udata, e.data);
        chk("start_gid", 32'(gid), 32'(e.gid));
        chk("start_cycle", 32'(cyc), 32'(e.at));
        chk("start_busy", 32'(busy), 32'd1);
      end
    end
    if (done != '0 || terr) begin
      if (dq.size() == 0) unexpected("done", 32'(done));
      else begin
        e = dq.pop_front();
        chk("done_mask", 32'(done), 32'(e.mask));
        chk("done_terr", 32'(terr), 32'(e.terr));
        chk("done_data", udata, e.data);
        chk("done_gid", 32'(gid), 32'(e.gid));
        chk("done_cycle", 32'(cyc), 32'(e.at));
        chk("done_busy", 32'(busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (start_g || ack_g != '0) begin
      if (sq_g.size() == 0) unexpected("g0_start", 32'(ack_g));
      else begin
        e = sq_g.pop_front();
        chk("g0_start_ack", 32'(ack_g), 32'(e.mask));
        chk("g0_start_data", udata_g, e.data);
        chk("g0_start_gid", 32'(gid_g), 32'(e.gid));
        chk("g0_start_cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (done_g != '0 || terr_g) begin
      if (dq_g.size() == 0) unexpected("g0_done", 32'(done_g));
      else begin
        e = dq_g.pop_front();
        chk("g0_done_mask", 32'(done_g), 32'(e.mask));
        chk("g0_done_terr", 32'(terr_g), 32'(e.terr));
        chk("g0_done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_terr"}, 32'(terr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_data"}, udata, 32'd0);
    chk({tag, "_gid"}, 32'(gid), 32'd0);
  endtask

  initial begin
    int s;
    step(2);
    chk_all_zero("reset");
    chk("reset_g0_busy", 32'(busy_g), 32'd0);
    rst = 1'b0;
    step(2);

    // all four requesting continuously: order 0,1,2,3,0
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(32'h11111111 * (i + 1));
    req = 4'b1111;
    s = cyc + 1;
    for (int n = 0; n < 5; n++) begin
      sq.push_back(mk(mtab[n], dtab[n], gtab[n], 1'b0, s));
      step(s + dl[n] - 1 - cyc);
      txd = 1'b1;
      dq.push_back(mk(mtab[n], dtab[n], gtab[n], 1'b0, s + dl[n]));
      step(1);
      txd = 1'b0;
      s = s + dl[n] + GAP + 1;
    end
    req = '0;
    step(20);

    // single requester, tx_done 50 cycles after start, spurious tx_done in GAP
    req_data[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    s = cyc + 1;
    sq.push_back(mk(4'b0001, 32'hDEADBEEF, 2'd0, 1'b0, s));
    step(1);
    req = '0;
    step(49);
    txd = 1'b1;
    dq.push_back(mk(4'b0001, 32'hDEADBEEF, 2'd0, 1'b0, s + 50));
    step(1);
    txd = 1'b0;
    step(4);
    txd = 1'b1;
    step(1);
    txd = 1'b0;
    step(10);
    chk("gap_busy_last", 32'(busy), 32'd1);
    step(1);
    chk("gap_busy_end", 32'(busy), 32'd0);
    step(5);

    // timeout with no tx_done, then a normal frame
    req_data[63:32] = 32'hCAFEF00D;
    req = 4'b0010;
    s = cyc + 1;
    sq.push_back(mk(4'b0010, 32'hCAFEF00D, 2'd1, 1'b0, s));
    dq.push_back(mk(4'b0010, 32'hCAFEF00D, 2'd1, 1'b1, s + TO));
    step(1);
    req = '0;
    step(TO + GAP + 2);
    req_data[95:64] = 32'h5A5A5A5A;
    req = 4'b0100;
    s = cyc + 1;
    sq.push_back(mk(4'b0100, 32'h5A5A5A5A, 2'd2, 1'b0, s));
    step(1);
    req = '0;
    step(7);
    txd = 1'b1;
    dq.push_back(mk(4'b0100, 32'h5A5A5A5A, 2'd2, 1'b0, s + 8));
    step(1);
    txd = 1'b0;
    step(20);

    // tx_done on the timeout edge: plain done, no timeout_err
    req_data[127:96] = 32'h13579BDF;
    req = 4'b1000;
    s = cyc + 1;
    sq.push_back(mk(4'b1000, 32'h13579BDF, 2'd3, 1'b0, s));
    step(1);
    req = '0;
    step(TO - 1);
    txd = 1'b1;
    dq.push_back(mk(4'b1000, 32'h13579BDF, 2'd3, 1'b0, s + TO));
    step(1);
    txd = 1'b0;
    step(20);

    // reset in WAIT_DONE, then req 1001 -> requester 0 first
    req_data[31:0] = 32'h0F0F0F0F;
    req = 4'b0001;
    sq.push_back(mk(4'b0001, 32'h0F0F0F0F, 2'd0, 1'b0, cyc + 1));
    step(1);
    req = '0;
    step(9);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    step(2);
    rst = 1'b0;
    req_data[31:0]   = 32'hAAAA0000;
    req_data[127:96] = 32'hBBBB3333;
    req = 4'b1001;
    s = cyc + 1;
    sq.push_back(mk(4'b0001, 32'hAAAA0000, 2'd0, 1'b0, s));
    step(1);
    req = 4'b1000;
    step(3);
    txd = 1'b1;
    dq.push_back(mk(4'b0001, 32'hAAAA0000, 2'd0, 1'b0, s + 4));
    sq.push_back(mk(4'b1000, 32'hBBBB3333, 2'd3, 1'b0, s + 4 + GAP + 1));
    step(1);
    txd = 1'b0;
    step(17);
    req = '0;
    step(2);
    txd = 1'b1;
    dq.push_back(mk(4'b1000, 32'hBBBB3333, 2'd3, 1'b0, s + 4 + GAP + 1 + 3));
    step(1);
    txd = 1'b0;
    step(20);

    // no-gap instance: spurious tx_done in IDLE, then back-to-back frames
    txd_g = 1'b1;
    step(1);
    txd_g = 1'b0;
    step(3);
    req_data_g[31:0]  = 32'h01010101;
    req_data_g[63:32] = 32'h02020202;
    req_g = 4'b0011;
    s = cyc + 1;
    sq_g.push_back(mk(4'b0001, 32'h01010101, 2'd0, 1'b0, s));
    step(1);
    req_g = 4'b0010;
    step(5);
    txd_g = 1'b1;
    dq_g.push_back(mk(4'b0001, 32'h01010101, 2'd0, 1'b0, s + 6));
    sq_g.push_back(mk(4'b0010, 32'h02020202, 2'd1, 1'b0, s + 7));
    step(1);
    txd_g = 1'b0;
    step(1);
    req_g = '0;
    step(2);
    txd_g = 1'b1;
    dq_g.push_back(mk(4'b0010, 32'h02020202, 2'd1, 1'b0, s + 10));
    step(1);
    txd_g = 1'b0;
    step(5);

    chk("left_start", 32'(sq.size()), 32'd0);
    chk("left_done", 32'(dq.size()), 32'd0);
    chk("left_g0_start", 32'(sq_g.size()), 32'd0);
    chk("left_g0_done", 32'(dq_g.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter among NUM_REQ requesters using round-robin arbitration.
- Each requester offers one 32-bit word per request; the block launches exactly one frame at a time by pulsing start to uart_tx.
- It then waits for tx_done, enforces an inter-frame guard gap, and reports completion or timeout back to the owning requester.
- Sits between the client logic and the uart top, driving its data_in/start and consuming its tx_done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle clk cycles between tx_done and next launch (0 = no gap)
TIMEOUT_CYCLES, 1000000, max clk cycles waiting for tx_done before abort (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request; held high with stable data until ack
req_data  input  32*NUM_REQ  word i at bits [32*i+31:32*i]
ack  output  NUM_REQ  one-cycle pulse: word accepted, requester may change data/drop req
done  output  NUM_REQ  one-cycle pulse: frame finished (normal or timeout) for that requester
timeout_err  output  1  one-cycle pulse coincident with done on timeout abort
busy  output  1  high in any state other than IDLE
grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester
uart_start  output  1  one-cycle start pulse to uart_tx
uart_data  output  32  word to uart_tx data_in, stable from uart_start until done
uart_tx_done  input  1  tx_done from uart_tx, single-cycle pulse

Behaviour:
- Reset (async, while rst=1): state=IDLE, ack=0, done=0, timeout_err=0, busy=0, uart_start=0, uart_data=0, grant_id=0, counters=0, rr pointer=NUM_REQ-1 (req[0] has first priority).
- All outputs are registered.
- States: IDLE, WAIT_DONE, GAP.
- IDLE, req!=0 at edge k:
  - Pick the first set bit searching from pointer+1 upward with wrap.
  - Latch uart_data=req_data[winner] and grant_id=winner; pointer=winner.
  - In the cycle after edge k: uart_start=1 and ack[winner]=1, each for exactly one cycle. State -> WAIT_DONE, timeout counter cleared.
- IDLE, req==0: stay; no outputs change.
- WAIT_DONE:
  - Counter increments every cycle.
  - uart_tx_done sampled high at edge m: done[grant_id]=1 in the next cycle. State -> GAP, or -> IDLE if GAP_CYCLES=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no tx_done: done[grant_id]=1 and timeout_err=1 for one cycle, same next-state rule.
  - tx_done and timeout on the same edge: tx_done wins, no timeout_err.
- GAP: counts GAP_CYCLES cycles, then -> IDLE. The earliest next uart_start is GAP_CYCLES+2 cycles after the tx_done edge.
- uart_tx_done in IDLE or GAP is ignored, with no done pulse.
- A request dropped before ack is simply not served; no error.
- req of the winner held across its own done is a new request and competes normally. Round-robin means another pending requester is served first.
- Only one ack and at most one done are ever high per cycle; ack and done never target different frames in the same cycle.
- Reset mid-frame: frame abandoned without done; the uart is not told; requesters must re-request.
- busy=1 from the uart_start cycle through the last GAP cycle.

Test Plan:
- Single requester: req=0001, req_data[31:0]=0xDEADBEEF -> one cycle later uart_start=1, ack=0001, uart_data=0xDEADBEEF; model tx_done 50 cycles later -> done=0001 next cycle, busy low after 16 gap cycles.
- All four request continuously with data 0x11111111..0x44444444 -> launch order 0,1,2,3,0; each uart_data matches its owner; consecutive starts separated by >= GAP_CYCLES+2 cycles after tx_done.
- Timeout with TIMEOUT_CYCLES=100 and no tx_done -> done[grant_id] and timeout_err pulse exactly 100 cycles after uart_start; next request served normally.
- tx_done on the same edge as timeout -> done pulse only, timeout_err stays 0.
- rst asserted in WAIT_DONE -> all outputs 0 immediately; after release, req=1000 and 0001 together -> requester 0 granted first.
- Spurious uart_tx_done in IDLE, and with GAP_CYCLES=0 back-to-back requests -> no done on the spurious pulse; second uart_start two cycles after the first tx_done edge.
